// File: rtl/rv32i_memoryaccess.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_memoryaccess
// Brief   : RV32I memory stage; one bus transaction per load/store, ack timeout.
//           Optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision: 1.0 - initial release
// ============================================================================
module rv32i_memoryaccess #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_y,
   input  logic [31:0] i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_load,
   input  logic        i_store,
   input  logic [4:0]  i_rd_addr,
   input  logic        i_flush,
   output logic        o_req,
   output logic        o_we,
   output logic [31:0] o_addr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wsel,
   input  logic        i_ack,
   input  logic [31:0] i_rdata,
   output logic        o_valid,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_result,
   output logic        o_err
);

   localparam int c_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST =
      (ACK_TIMEOUT > 0) ? c_CNT_W'(ACK_TIMEOUT - 1) : '0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUS  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [2:0]          r_funct3;
   logic [1:0]          r_off;
   logic                r_is_load;
   logic                r_flushed;
   logic [4:0]          r_rd_addr;

   logic                w_accept;
   logic                w_is_mem;
   logic                w_is_store;
   logic                w_size_byte;
   logic                w_size_half;
   logic                w_misalign;
   logic                w_start_bus;
   logic                w_ack;
   logic                w_timeout;
   logic                w_suppress;
   logic [31:0]         w_wdata;
   logic [3:0]          w_wsel;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load_data;

   assign o_ready     = (r_state == IDLE);
   assign w_accept    = i_valid & o_ready & ~i_flush;
   assign w_is_mem    = i_load | i_store;
   // Both load and store asserted is treated as a load.
   assign w_is_store  = i_store & ~i_load;
   assign w_size_byte = (i_funct3[1:0] == 2'b00);
   assign w_size_half = (i_funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = w_is_mem &
                       ((w_size_half & i_y[0]) |
                        (~w_size_byte & ~w_size_half & (i_y[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_start_bus = w_accept & w_is_mem & ~w_misalign;
   assign w_ack       = (r_state == BUS) & i_ack;
   assign w_timeout   = (ACK_TIMEOUT != 0) & (r_state == BUS) & ~i_ack &
                        (r_cnt == c_CNT_LAST);
   assign w_suppress  = r_flushed | i_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start_bus) w_state_nxt = BUS;
         BUS:     if (w_ack || w_timeout) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_wsel  = 4'b1111;
      w_wdata = '0;
      if (w_is_store) begin
         if (w_size_byte) begin
            w_wdata = {4{i_rs2[7:0]}};
            w_wsel  = 4'b0001 << i_y[1:0];
         end else if (w_size_half) begin
            w_wdata = {2{i_rs2[15:0]}};
            w_wsel  = 4'b0011 << {i_y[1], 1'b0};
         end else begin
            w_wdata = i_rs2;
         end
      end
   end

   always_comb begin
      w_byte = i_rdata[7:0];
      case (r_off)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = r_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      // funct3[2] selects zero-extension (LBU/LHU).
      if (r_funct3[1:0] == 2'b00) begin
         w_load_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      end else if (r_funct3[1:0] == 2'b01) begin
         w_load_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      end else begin
         w_load_data = i_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_req     <= 1'b0;
         o_we      <= 1'b0;
         o_addr    <= '0;
         o_wdata   <= '0;
         o_wsel    <= '0;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
         o_result  <= '0;
         o_rd_addr <= '0;
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_off     <= '0;
         r_is_load <= 1'b0;
         r_flushed <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (!w_is_mem || w_misalign) begin
                     o_valid   <= 1'b1;
                     o_err     <= w_misalign;
                     o_result  <= w_misalign ? 32'h0 : i_y;
                     o_rd_addr <= i_rd_addr;
                  end else begin
                     o_req     <= 1'b1;
                     o_we      <= w_is_store;
                     o_addr    <= {i_y[31:2], 2'b00};
                     o_wdata   <= w_wdata;
                     o_wsel    <= w_wsel;
                     r_funct3  <= i_funct3;
                     r_off     <= i_y[1:0];
                     r_is_load <= ~w_is_store;
                     r_rd_addr <= i_rd_addr;
                     r_flushed <= 1'b0;
                     r_cnt     <= '0;
                  end
               end
            end
            BUS: begin
               r_cnt <= r_cnt + 1'b1;
               if (i_flush) r_flushed <= 1'b1;
               // A flushed transaction still completes on the bus, silently.
               if (w_ack || w_timeout) begin
                  o_req     <= 1'b0;
                  o_we      <= 1'b0;
                  o_valid   <= ~w_suppress;
                  o_err     <= w_timeout & ~w_suppress;
                  o_result  <= (w_ack && r_is_load) ? w_load_data : 32'h0;
                  o_rd_addr <= r_rd_addr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_memoryaccess.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32i_memoryaccess
// Brief   : Table-driven and randomized bench for rv32i_memoryaccess.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32i_memoryaccess;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, i_load, i_store, i_flush, i_ack;
   logic [31:0] i_y, i_rs2, i_rdata;
   logic [2:0]  i_funct3;
   logic [4:0]  i_rd_addr;
   logic        o_ready, o_req, o_we, o_valid, o_err;
   logic [31:0] o_addr, o_wdata, o_result;
   logic [3:0]  o_wsel;
   logic [4:0]  o_rd_addr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv32i_memoryaccess #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_load(i_load),
      .i_store(i_store), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
      .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
      .o_wsel(o_wsel), .i_ack(i_ack), .i_rdata(i_rdata), .o_valid(o_valid),
      .o_rd_addr(o_rd_addr), .o_result(o_result), .o_err(o_err)
   );

   typedef struct {
      logic [2:0]  f3;
      logic        ld, st;
      logic [31:0] y, rs2, rdata;
      logic [4:0]  rd;
      int          dly;
      logic        fl_in, fl_bus;
   } op_t;

   typedef struct {
      int          req_cyc;
      logic [31:0] addr;
      logic        we, chk_wd;
      logic [31:0] wdata;
      logic [3:0]  wsel;
      logic        valid, err;
      logic [31:0] result;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t ex;
   } vec_t;

   function automatic op_t mk_op(input logic [2:0] f3, input logic ld, input logic st,
                                 input logic [31:0] y, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input logic [4:0] rd,
                                 input int dly, input logic fl_in, input logic fl_bus);
      op_t o;
      o.f3 = f3; o.ld = ld; o.st = st; o.y = y; o.rs2 = rs2; o.rdata = rdata;
      o.rd = rd; o.dly = dly; o.fl_in = fl_in; o.fl_bus = fl_bus;
      return o;
   endfunction

   function automatic exp_t mk_ex(input int req_cyc, input logic [31:0] addr,
                                  input logic we, input logic chk_wd,
                                  input logic [31:0] wdata, input logic [3:0] wsel,
                                  input logic valid, input logic err,
                                  input logic [31:0] result);
      exp_t e;
      e.req_cyc = req_cyc; e.addr = addr; e.we = we; e.chk_wd = chk_wd;
      e.wdata = wdata; e.wsel = wsel; e.valid = valid; e.err = err;
      e.result = result;
      return e;
   endfunction

   // Reference: access size in bytes, lane offset arithmetic, extension by range.
   function automatic exp_t model(input op_t o);
      exp_t   e;
      int     sz, off, lane;
      bit     mem, mis, tmo;
      longint v;
      mem = o.ld || o.st;
      off = int'(o.y % 4);
      sz  = (o.f3[1:0] == 2'b00) ? 1 : (o.f3[1:0] == 2'b01) ? 2 : 4;
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = mem && ((off % sz) != 0);
`endif
      e.addr   = o.y - 32'(off);
      e.we     = mem && !o.ld;
      e.chk_wd = e.we;
      e.wsel   = 4'hF;
      e.wdata  = 32'h0;
      if (e.we) begin
         if (sz == 1) begin
            e.wdata = (o.rs2 & 32'hFF) * 32'h0101_0101;
            e.wsel  = 4'(1 << off);
         end else if (sz == 2) begin
            e.wdata = (o.rs2 & 32'hFFFF) * 32'h0001_0001;
            e.wsel  = 4'(3 << (2 * (off / 2)));
         end else begin
            e.wdata = o.rs2;
         end
      end
      e.req_cyc = (!mem || mis || o.fl_in) ? 0 : ((o.dly < TO) ? o.dly + 1 : TO);
      tmo       = mem && !mis && (o.dly >= TO);
      e.valid   = !o.fl_in && !(e.req_cyc > 0 && o.fl_bus);
      e.err     = mis || tmo;
      if (!mem) begin
         e.result = o.y;
      end else if (mis || tmo || !o.ld) begin
         e.result = 32'h0;
      end else begin
         lane = (sz == 1) ? off : (sz == 2) ? (off / 2) * 2 : 0;
         v    = longint'(o.rdata) >> (8 * lane);
         if (sz < 4) begin
            v = v % (longint'(1) << (8 * sz));
            if (!o.f3[2] && v >= (longint'(1) << (8 * sz - 1)))
               v = v - (longint'(1) << (8 * sz));
         end
         e.result = 32'(v);
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string nm);
      chk({nm, ".req"},    32'(o_req),     32'h0);
      chk({nm, ".we"},     32'(o_we),      32'h0);
      chk({nm, ".valid"},  32'(o_valid),   32'h0);
      chk({nm, ".err"},    32'(o_err),     32'h0);
      chk({nm, ".addr"},   o_addr,         32'h0);
      chk({nm, ".wdata"},  o_wdata,        32'h0);
      chk({nm, ".result"}, o_result,       32'h0);
      chk({nm, ".wsel"},   32'(o_wsel),    32'h0);
      chk({nm, ".rd"},     32'(o_rd_addr), 32'h0);
      chk({nm, ".ready"},  32'(o_ready),   32'h1);
   endtask

   task automatic run(input string nm, input op_t o, input exp_t e);
      int   n;
      logic stable;
      chk({nm, ".ready"}, 32'(o_ready), 32'h1);
      i_valid = 1'b1; i_funct3 = o.f3; i_load = o.ld; i_store = o.st;
      i_y = o.y; i_rs2 = o.rs2; i_rd_addr = o.rd; i_flush = o.fl_in;
      tick();
      i_valid = 1'b0; i_flush = 1'b0;
      i_y = $urandom; i_rs2 = $urandom; i_funct3 = 3'($urandom);
      i_load = 1'($urandom); i_store = 1'($urandom); i_rd_addr = 5'($urandom);
      if (e.req_cyc > 0) begin
         chk({nm, ".addr"}, o_addr, e.addr);
         chk({nm, ".we"}, 32'(o_we), 32'(e.we));
         chk({nm, ".wsel"}, 32'(o_wsel), 32'(e.wsel));
         if (e.chk_wd) chk({nm, ".wdata"}, o_wdata, e.wdata);
      end
      n = 0;
      stable = 1'b1;
      while (o_req && n < 3 * TO) begin
         if (o_addr !== e.addr || o_we !== e.we || o_wsel !== e.wsel ||
             (e.chk_wd && o_wdata !== e.wdata) || o_valid !== 1'b0)
            stable = 1'b0;
         i_flush = o.fl_bus && (n == 0);
         i_ack   = (n == o.dly);
         i_rdata = i_ack ? o.rdata : $urandom;
         tick();
         n++;
         i_ack = 1'b0; i_flush = 1'b0;
      end
      chk({nm, ".req_cycles"}, 32'(n), 32'(e.req_cyc));
      chk({nm, ".hold"}, 32'(stable), 32'h1);
      chk({nm, ".req_off"}, 32'(o_req), 32'h0);
      chk({nm, ".valid"}, 32'(o_valid), 32'(e.valid));
      if (e.valid) begin
         chk({nm, ".err"}, 32'(o_err), 32'(e.err));
         chk({nm, ".result"}, o_result, e.result);
         chk({nm, ".rd"}, 32'(o_rd_addr), 32'(o.rd));
      end
      i_ack = 1'($urandom);
      i_rdata = $urandom;
      tick();
      i_ack = 1'b0;
      chk({nm, ".pulse"}, 32'(o_valid), 32'h0);
      chk({nm, ".idle_req"}, 32'(o_req), 32'h0);
   endtask

   vec_t tbl [12];

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_flush = 1'b0;
      i_ack = 1'b0; i_y = '0; i_rs2 = '0; i_rdata = '0; i_funct3 = '0; i_rd_addr = '0;

      tbl[0]  = '{mk_op(3'b000, 0, 0, 32'h0000_1234, 0, 0, 5'd5, 0, 0, 0),
                  mk_ex(0, 0, 0, 0, 0, 4'hF, 1, 0, 32'h0000_1234)};
      tbl[1]  = '{mk_op(3'b000, 1, 0, 32'h103, 0, 32'h80FF_FFFF, 5'd7, 3, 0, 0),
                  mk_ex(4, 32'h100, 0, 0, 0, 4'hF, 1, 0, 32'hFFFF_FF80)};
      tbl[2]  = '{mk_op(3'b001, 0, 1, 32'h202, 32'h0000_ABCD, 0, 5'd0, 1, 0, 0),
                  mk_ex(2, 32'h200, 1, 1, 32'hABCD_ABCD, 4'b1100, 1, 0, 32'h0)};
      tbl[3]  = '{mk_op(3'b010, 1, 0, 32'h100, 0, 0, 5'd9, 99, 0, 0),
                  mk_ex(4, 32'h100, 0, 0, 0, 4'hF, 1, 1, 32'h0)};
`ifdef MISALIGN_TRAP_EN
      tbl[4]  = '{mk_op(3'b010, 1, 0, 32'h102, 0, 32'h1122_3344, 5'd3, 0, 0, 0),
                  mk_ex(0, 32'h100, 0, 0, 0, 4'hF, 1, 1, 32'h0)};
`else
      tbl[4]  = '{mk_op(3'b010, 1, 0, 32'h102, 0, 32'h1122_3344, 5'd3, 0, 0, 0),
                  mk_ex(1, 32'h100, 0, 0, 0, 4'hF, 1, 0, 32'h1122_3344)};
`endif
      tbl[5]  = '{mk_op(3'b101, 1, 0, 32'h106, 0, 32'h89AB_CDEF, 5'd4, 2, 0, 0),
                  mk_ex(3, 32'h104, 0, 0, 0, 4'hF, 1, 0, 32'h0000_89AB)};
      tbl[6]  = '{mk_op(3'b001, 1, 0, 32'h106, 0, 32'h89AB_CDEF, 5'd4, 0, 0, 0),
                  mk_ex(1, 32'h104, 0, 0, 0, 4'hF, 1, 0, 32'hFFFF_89AB)};
      tbl[7]  = '{mk_op(3'b000, 0, 1, 32'h301, 32'h1234_56A5, 0, 5'd0, 0, 0, 0),
                  mk_ex(1, 32'h300, 1, 1, 32'hA5A5_A5A5, 4'b0010, 1, 0, 32'h0)};
      tbl[8]  = '{mk_op(3'b100, 1, 0, 32'h2, 0, 32'h00C3_0000, 5'd1, 1, 0, 0),
                  mk_ex(2, 32'h0, 0, 0, 0, 4'hF, 1, 0, 32'h0000_00C3)};
      tbl[9]  = '{mk_op(3'b010, 1, 0, 32'h40, 0, 32'h5555_5555, 5'd2, 1, 0, 1),
                  mk_ex(2, 32'h40, 0, 0, 0, 4'hF, 0, 0, 32'h0)};
      tbl[10] = '{mk_op(3'b010, 0, 1, 32'h80, 32'h7777_7777, 0, 5'd0, 0, 1, 0),
                  mk_ex(0, 32'h80, 1, 1, 32'h7777_7777, 4'hF, 0, 0, 32'h0)};
      tbl[11] = '{mk_op(3'b111, 1, 1, 32'h8, 32'h1111_1111, 32'hDEAD_BEEF, 5'd31, 0, 0, 0),
                  mk_ex(1, 32'h8, 0, 0, 0, 4'hF, 1, 0, 32'hDEAD_BEEF)};

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      tick();
      chk("reset.ready_after", 32'(o_ready), 32'h1);

      for (int k = 0; k < 12; k++) run($sformatf("vec%0d", k), tbl[k].op, tbl[k].ex);

      // Reset in the middle of a bus cycle, then a late ack that must be ignored.
      i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010;
      i_y = 32'h500; i_rd_addr = 5'd6; i_flush = 1'b0;
      tick();
      i_valid = 1'b0;
      chk("midrst.req", 32'(o_req), 32'h1);
      tick();
      rst_n = 1'b0;
      tick();
      check_zero("midrst");
      rst_n = 1'b1;
      i_ack = 1'b1; i_rdata = 32'hCAFE_F00D;
      tick();
      i_ack = 1'b0;
      chk("midrst.no_valid", 32'(o_valid), 32'h0);
      chk("midrst.ready", 32'(o_ready), 32'h1);
      chk("midrst.no_req", 32'(o_req), 32'h0);

      for (int k = 0; k < 200; k++) begin
         op_t o;
         int  kind;
         kind     = int'($urandom_range(0, 3));
         o.f3     = 3'($urandom);
         o.ld     = (kind == 1 || kind == 3);
         o.st     = (kind == 2 || kind == 3);
         o.y      = $urandom;
         o.rs2    = $urandom;
         o.rdata  = $urandom;
         o.rd     = 5'($urandom);
         o.dly    = int'($urandom_range(0, 5));
         o.fl_in  = ($urandom_range(0, 15) == 0);
         o.fl_bus = ($urandom_range(0, 7) == 0);
         run($sformatf("rnd%0d", k), o, model(o));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
